div_seq: RTL and testbench

Iterative signed fixed-point divider: o = a / b, one quotient bit per clock, with a valid/ready handshake on both sides, clean saturation, and divide-by-zero and saturation flags. It is the parametrised successor to the single-cycle combinational-division stage in the HOG gradient/normalisation path. It replaces the wide `/` operator with a restoring shifter so the block closes timing at the pixel clock on the FPGA.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_seq_step.sv | 22 ++
 rtl/div_seq.sv | 154 +++++++++++++++
 tb/tb_div_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and saturation helpers for the sequential signed divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Largest positive two's-complement value of a w-bit word.
   function automatic logic [31:0] sat_max(input int w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // Bit pattern of the most negative w-bit value (also its magnitude).
   function automatic logic [31:0] sat_min(input int w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_seq_step #(
   parameter int B_W = 9
) (
   input  logic [B_W:0]   rem,
   input  logic [B_W-1:0] div,
   input  logic           bit_in,
   output logic [B_W:0]   rem_nxt,
   output logic           q
);

   logic [B_W:0] shifted;

   assign shifted = {rem[B_W-1:0], bit_in};

   // rem stays below div, so its top bit is never set; it is folded in only as a safe fit.
   always_comb begin
      q       = rem[B_W] | (shifted >= {1'b0, div});
      rem_nxt = q ? (shifted - {1'b0, div}) : shifted;
   end

endmodule

// File: rtl/div_seq.sv
// Iterative signed fixed-point divider o = a / b, one quotient bit per clock,
// valid/ready on both sides, saturating output with divide-by-zero and clip flags.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | restoring iteration, Q_W cycles
// DONE  | result registered and held until out_ready
module div_seq
   import div_pkg::*;
#(
   parameter int A_W   = 9,
   parameter int B_W   = 9,
   parameter int O_I_W = 4,
   parameter int O_F_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [A_W-1:0]           a,
   input  logic [B_W-1:0]           b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [O_I_W+O_F_W-1:0]   o,
   output logic                     dz,
   output logic                     sat
);

   localparam int O_W   = O_I_W + O_F_W;
   localparam int Q_W   = A_W + O_F_W;
   localparam int CNT_W = $clog2(Q_W + 1);

   localparam logic [O_W-1:0] MAX_O   = O_W'(sat_max(O_W));
   localparam logic [O_W-1:0] MIN_O   = O_W'(sat_min(O_W));
   localparam logic [Q_W-1:0] MAX_Q   = Q_W'(sat_max(O_W));
   localparam logic [Q_W-1:0] MIN_MAG = Q_W'(sat_min(O_W));

   state_t state, state_nxt;
   logic accept, step, fin, take;

   logic [Q_W-1:0]   quo;
   logic [B_W:0]     rem, rem_nxt;
   logic [B_W-1:0]   b_mag;
   logic [CNT_W-1:0] cnt;
   logic             neg, a_neg, zero, q_bit;

   logic [A_W-1:0]   a_abs;
   logic [B_W-1:0]   b_abs;
   logic [O_W-1:0]   res_o;
   logic             res_dz, res_sat;

   assign a_abs    = a[A_W-1] ? (~a + A_W'(1)) : a;
   assign b_abs    = b[B_W-1] ? (~b + B_W'(1)) : b;
   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      fin       = 1'b0;
      take      = 1'b0;
      case (state)
         IDLE: if (in_valid) begin
            accept    = 1'b1;
            state_nxt = CALC;
         end
         CALC: begin
            step = 1'b1;
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            // First DONE cycle registers the signed result; the handshake can only follow it.
            if (!out_valid) begin
               fin = 1'b1;
            end else if (out_ready) begin
               take      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   div_seq_step #(.B_W(B_W)) u_step (
      .rem     (rem),
      .div     (b_mag),
      .bit_in  (quo[Q_W-1]),
      .rem_nxt (rem_nxt),
      .q       (q_bit)
   );

   always_comb begin
      res_o   = '0;
      res_dz  = 1'b0;
      res_sat = 1'b0;
      if (zero) begin
         res_dz = 1'b1;
         res_o  = a_neg ? -MAX_O : MAX_O;
      end else if (!neg && (quo > MAX_Q)) begin
         res_o   = MAX_O;
         res_sat = 1'b1;
      end else if (neg && (quo > MIN_MAG)) begin
         res_o   = MIN_O;
         res_sat = 1'b1;
      end else begin
         res_o = neg ? -quo[O_W-1:0] : quo[O_W-1:0];
      end
   end

   // quo starts as the shifted dividend and fills with quotient bits from the LSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo       <= '0;
         rem       <= '0;
         b_mag     <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         a_neg     <= 1'b0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
         o         <= '0;
         dz        <= 1'b0;
         sat       <= 1'b0;
      end else begin
         if (accept) begin
            quo   <= {a_abs, {O_F_W{1'b0}}};
            rem   <= '0;
            b_mag <= b_abs;
            cnt   <= CNT_W'(Q_W - 1);
            neg   <= a[A_W-1] ^ b[B_W-1];
            a_neg <= a[A_W-1];
            zero  <= (b == '0);
         end
         if (step) begin
            quo <= {quo[Q_W-2:0], q_bit};
            rem <= rem_nxt;
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
         end
         if (fin) begin
            out_valid <= 1'b1;
            o         <= res_o;
            dz        <= res_dz;
            sat       <= res_sat;
         end
         if (take) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases, handshake hold, reset abort, random operands.
module tb_div_seq;

   localparam int A_W = 9;
   localparam int B_W = 9;
   localparam int O_W = 20;
   localparam int LAT = 26;
   localparam longint MAXV = (64'sd1 <<< (O_W - 1)) - 1;
   localparam longint MINV = -(64'sd1 <<< (O_W - 1));

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [A_W-1:0]   a = '0;
   logic [B_W-1:0]   b = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [O_W-1:0]   o;
   logic             dz;
   logic             sat;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   div_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .dz        (dz),
      .sat       (sat)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: scaled integer division truncating toward zero, then clamp to the output range.
   task automatic model(input int av, input int bv,
                        output logic [O_W-1:0] eo, output logic edz, output logic esat);
      longint q;
      edz  = 1'b0;
      esat = 1'b0;
      if (bv == 0) begin
         edz = 1'b1;
         q   = (av >= 0) ? MAXV : -MAXV;
      end else begin
         q = (longint'(av) * 65536) / longint'(bv);
         if (q > MAXV) begin q = MAXV; esat = 1'b1; end
         else if (q < MINV) begin q = MINV; esat = 1'b1; end
      end
      eo = q[O_W-1:0];
   endtask

   task automatic run_op(input logic signed [A_W-1:0] av, input logic signed [B_W-1:0] bv,
                         input int hold);
      logic [O_W-1:0] eo;
      logic           edz, esat;
      int             lat;
      for (int i = 0; i < 100 && !in_ready; i++) cyc();
      chk("ready_before_op", in_ready, 1'b1);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      cyc();
      // Keep offering different operands while busy; they must be ignored.
      a = ~av;
      b = bv + 9'sd1;
      lat = 0;
      while (!out_valid && lat < 100) begin
         chk("busy_not_ready", in_ready, 1'b0);
         cyc();
         lat++;
      end
      model(int'(av), int'(bv), eo, edz, esat);
      chk($sformatf("latency a=%0d b=%0d", av, bv), lat, LAT);
      chk($sformatf("o a=%0d b=%0d", av, bv), o, eo);
      chk($sformatf("dz a=%0d b=%0d", av, bv), dz, edz);
      chk($sformatf("sat a=%0d b=%0d", av, bv), sat, esat);
      for (int i = 0; i < hold; i++) begin
         cyc();
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_o", o, eo);
         chk("hold_flags", {dz, sat}, {edz, esat});
         chk("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("after_take_valid", out_valid, 1'b0);
      chk("after_take_ready", in_ready, 1'b1);
   endtask

   initial begin
      logic signed [A_W-1:0] ra;
      logic signed [B_W-1:0] rb;

      #2;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_o", o, '0);
      chk("rst_flags", {dz, sat}, 2'b00);
      cyc();
      rst_n = 1'b1;
      cyc();

      run_op(9'sd3, 9'sd2, 0);
      run_op(-9'sd3, 9'sd2, 0);
      run_op(9'sd1, 9'sd3, 0);
      run_op(-9'sd1, 9'sd3, 0);
      run_op(9'sd100, 9'sd3, 0);
      run_op(-9'sd256, 9'sd1, 0);
      run_op(-9'sd128, 9'sd1, 0);
      run_op(-9'sd8, 9'sd1, 0);
      run_op(9'sd8, -9'sd1, 0);
      run_op(9'sd7, -9'sd1, 0);
      run_op(9'sd5, 9'sd0, 0);
      run_op(-9'sd5, 9'sd0, 0);
      run_op(9'sd0, 9'sd0, 0);
      run_op(9'sd0, -9'sd7, 0);
      run_op(9'sd255, -9'sd256, 0);
      run_op(-9'sd256, -9'sd256, 0);
      run_op(9'sd3, 9'sd2, 10);

      // Abort mid-iteration with an async reset pulse.
      a        = 9'sd3;
      b        = 9'sd2;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      repeat (10) cyc();
      chk("pre_abort_busy", in_ready, 1'b0);
      rst_n = 1'b0;
      cyc();
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      cyc();
      run_op(9'sd3, 9'sd2, 0);

      for (int n = 0; n < 40; n++) begin
         ra = A_W'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = B_W'($urandom_range(0, 4)) * (($urandom_range(0, 1) == 1) ? -9'sd1 : 9'sd1);
            default: rb = B_W'($urandom);
         endcase
         run_op(ra, rb, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
